// File: rtl/aes_result_display.sv
// aes_result_display: capture a selected AES channel result, compare it, and scroll it on seven-segment digits
module aes_result_display #(
    parameter int NCH   = 3,
    parameter int NDIG  = 3,
    parameter int DWELL = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            controller,
    input  logic [NCH-1:0]        ch_done,
    input  logic [128*NCH-1:0]    ch_data,
    input  logic [128*NCH-1:0]    ch_expect,
    output logic                  flag,
    output logic                  valid,
    output logic [7*NDIG-1:0]     sevenSeg
);
    localparam int W  = (32 + NDIG - 1) / NDIG;
    localparam int CW = $clog2(DWELL);
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    typedef enum logic [1:0] {IDLE, CAPTURE, SHOW} state_t;
    state_t         state_q, state_d;
    logic [2:0]     ctrl_q;
    logic           done_q, sel_done, changed, capture, show, wrap;
    logic [127:0]   sel_data, sel_exp, result, exp_q;
    logic [5:0]     win, win_nx;
    logic [CW-1:0]  cnt;

    function automatic logic [7*NDIG-1:0] digits(input logic [127:0] r, input logic [5:0] w);
        logic [7*NDIG-1:0] s;
        int idx;
        s = '0;
        for (int j = 0; j < NDIG; j++) begin
            idx = 31 - (int'(w) * NDIG + j);
            s[7*(NDIG-1-j) +: 7] = idx < 0 ? 7'h7F : GLYPH[r[4*idx +: 4]];
        end
        return s;
    endfunction

    always_comb begin
        sel_done = 1'b0;
        sel_data = '0;
        sel_exp  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (controller == 3'(i + 1)) begin
                sel_done = ch_done[i];
                sel_data = ch_data[128*i +: 128];
                sel_exp  = ch_expect[128*i +: 128];
            end
        end
        changed = controller != ctrl_q;
        // level-sensitive in IDLE, rising-edge-sensitive while showing
        capture = !changed && sel_done && (state_q == IDLE || (state_q == SHOW && !done_q));
        show    = !changed && state_q == CAPTURE;
        state_d = changed ? IDLE : capture ? CAPTURE : show ? SHOW : state_q;
        wrap    = cnt == CW'(DWELL - 1);
        win_nx  = wrap ? (win == 6'(W - 1) ? 6'd0 : win + 6'd1) : win;
    end

    always_ff @(posedge clk)
        state_q <= reset ? IDLE : state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q   <= '0;
            done_q   <= 1'b0;
            result   <= '0;
            exp_q    <= '0;
            flag     <= 1'b0;
            valid    <= 1'b0;
            sevenSeg <= '1;
            win      <= '0;
            cnt      <= '0;
        end else begin
            ctrl_q <= controller;
            done_q <= sel_done;
            if (capture) begin
                result <= sel_data;
                exp_q  <= sel_exp;
            end
            if (changed) begin
                flag     <= 1'b0;
                valid    <= 1'b0;
                sevenSeg <= '1;
                win      <= '0;
                cnt      <= '0;
            end else if (show) begin
                flag     <= result == exp_q;
                valid    <= 1'b1;
                sevenSeg <= digits(result, 6'd0);
                win      <= '0;
                cnt      <= '0;
            end else if (state_q == SHOW) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
                win <= win_nx;
                if (wrap)
                    sevenSeg <= digits(result, win_nx);
            end
        end
    end
endmodule

// File: doc/aes_result_display.md
AES_RESULT_DISPLAY -- requirements
Module: aes_result_display

Interface
REQ-001 Parameter NCH, default 3: number of AES result channels (1..7).
REQ-002 Parameter NDIG, default 3: number of seven-segment digits driven (1..8).
REQ-003 Parameter DWELL, default 50000000: clock cycles each scroll window is held (at least 2).
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port controller, input, 3: channel select; value k in 1..NCH selects channel k-1; 0 or >NCH selects none.
REQ-007 Port ch_done, input, NCH: per-channel AES completion level; bit i belongs to channel i.
REQ-008 Port ch_data, input, 128*NCH: per-channel ciphertext; channel i occupies bits [128*i+127 : 128*i].
REQ-009 Port ch_expect, input, 128*NCH: per-channel expected ciphertext, same packing as ch_data.
REQ-010 Port flag, output, 1: registered; 1 when the captured result equals the expected value.
REQ-011 Port valid, output, 1: registered; 1 while a captured result is being displayed.
REQ-012 Port sevenSeg, output, 7*NDIG: registered digits; the leftmost digit is bits [7*NDIG-1 -: 7].

Function
REQ-013 Segment code per digit SHALL be active-low, ordered {g,f,e,d,c,b,a}; blank = 7'h7F; hex glyphs include 0=7'h40, 1=7'h79, 5=7'h12, 6=7'h02, 8=7'h00, 9=7'h10, A=7'h08, C=7'h46, F=7'h0E.
REQ-014 The state machine SHALL have states IDLE, CAPTURE and SHOW.
REQ-015 IDLE: flag=0, valid=0, all digits blank.
REQ-016 IDLE -> CAPTURE when the selection is valid and the selected ch_done is 1 at a rising edge.
REQ-017 On that same edge, the selected ch_data SHALL be latched into a 128-bit result register and ch_expect into a 128-bit expect register.
REQ-018 CAPTURE lasts exactly one cycle, then -> SHOW.
REQ-019 On the CAPTURE->SHOW edge: flag <= (result == expect), valid <= 1, window <= 0, dwell counter <= 0, sevenSeg <= window 0.
REQ-020 Latency: flag, valid and first digits appear 2 cycles after the edge that sampled done=1.
REQ-021 Windows: number of windows W = ceil(32/NDIG).
REQ-022 Window w: digit j (j=0 leftmost) shows nibble index 31-(w*NDIG+j) of the result; indices below 0 show blank.
REQ-023 In SHOW, the dwell counter SHALL count 0..DWELL-1; at DWELL-1 it returns to 0 and the window advances.
REQ-024 The window SHALL advance from W-1 to 0 (wrap-around); SHOW persists indefinitely.
REQ-025 In SHOW, ch_done held high SHALL be ignored; a new 0->1 edge on the selected ch_done SHALL go to CAPTURE and re-latch the data.
REQ-026 The done edge detector SHALL track the selected channel only.
REQ-027 A registered copy of controller SHALL be kept; any change of controller SHALL force IDLE on the next edge from any state.
REQ-028 A controller change SHALL clear flag, valid, window and counter, and blank the digits.
REQ-029 A controller change SHALL take priority over a simultaneous done.
REQ-030 After a selection change, a selected ch_done already at 1 in IDLE SHALL trigger capture (level-sensitive in IDLE).
REQ-031 flag SHALL hold its value through SHOW until the next capture or IDLE.

Reset
REQ-032 On reset=1 at a rising edge: state IDLE, flag=0, valid=0, sevenSeg all 7'h7F, window=0, counter=0.
REQ-033 On reset=1 at a rising edge: result, expect and the registered controller are cleared to 0, and the edge detector is cleared.
REQ-034 Reset SHALL override all other inputs, including mid-SHOW or mid-CAPTURE.

Verification
REQ-035 Defaults, DWELL=4: controller=1, ch_done[0]=1, ch_data/ch_expect channel 0 = 69c4e0d86a7b0430d8cdb78070b4c55a -> 2 cycles later flag=1, valid=1, sevenSeg={7'h02,7'h10,7'h46}.
REQ-036 Same setup, run 40 cycles -> window 10 shows {7'h12,7'h08,7'h7F}, then wraps to window 0 after DWELL more cycles.
REQ-037 Channel 2 with expect differing in bit 0, controller=3 -> flag=0, valid=1, digits show the channel 2 data.
REQ-038 In SHOW, switch controller 1->2 in the same cycle that ch_done[1] rises -> next cycle IDLE, all 7'h7F, flag=0; capture of channel 1 follows one cycle later.
REQ-039 Assert reset mid-SHOW -> next cycle flag=0, valid=0, all 7'h7F; controller=0 with any ch_done -> remains IDLE.
REQ-040 In SHOW, pulse ch_done 1->0->1 with new data -> recapture; window restarts at 0 with the new digits 2 cycles after the rising edge.
